// File: rtl/pe_simd_mac.sv
`default_nettype none
// ============================================================================
// Module   : pe_simd_mac
// Purpose  : Weight-stationary SIMD processing element. LANES parallel MAC
//            lanes, each with a private weight register file, a registered
//            multiply stage (S1), a wide wrapping accumulator (S2) and
//            saturating narrowing of the finished dot product.
// Ports    : clk, rst (sync, active-low)
//            in_valid/in_ready      : input beat handshake
//            act, wgt               : packed per-lane activations / weights
//            use_reg, rd_addr       : select stored weight wreg[rd_addr]
//            wr_en, wr_addr         : write wgt into wreg[wr_addr], all lanes
//            signed_mode, last      : operand mode, final beat of dot product
//            out_valid/out_ready    : result handshake
//            out_data, out_sat      : narrowed results, per-lane clamp flags
// Revision : 1.0 - initial release
// ============================================================================
module pe_simd_mac #(
  parameter int IN_W       = 16,
  parameter int ACC_W      = 40,
  parameter int OUT_W      = 32,
  parameter int LANES      = 4,
  parameter int WREG_DEPTH = 8,
  parameter int AW         = (WREG_DEPTH > 1) ? $clog2(WREG_DEPTH) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*IN_W-1:0]  act,
  input  logic [LANES*IN_W-1:0]  wgt,
  input  logic                   use_reg,
  input  logic [AW-1:0]          rd_addr,
  input  logic                   wr_en,
  input  logic [AW-1:0]          wr_addr,
  input  logic                   signed_mode,
  input  logic                   last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*OUT_W-1:0] out_data,
  output logic [LANES-1:0]       out_sat
);

  localparam logic [AW:0] c_depth = WREG_DEPTH[AW:0];

  // --------------------------------------------------------------------------
  // Shared control
  // --------------------------------------------------------------------------
  logic r_s1_valid;
  logic r_s1_last;
  logic r_s1_signed;
  logic r_out_valid;

  logic w_stall;
  logic w_accept;
  logic w_adv;
  logic w_wr_ok;
  logic w_rd_ok;

  // Only a finishing beat can be blocked, and only by an unconsumed result.
  assign w_stall  = r_s1_valid & r_s1_last & r_out_valid & ~out_ready;
  assign in_ready = ~w_stall;
  assign w_accept = in_valid & ~w_stall;
  assign w_adv    = r_s1_valid & ~w_stall;
  assign w_wr_ok  = wr_en & ({1'b0, wr_addr} < c_depth);
  assign w_rd_ok  = ({1'b0, rd_addr} < c_depth);

  assign out_valid = r_out_valid;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_s1_valid  <= 1'b0;
      r_s1_last   <= 1'b0;
      r_s1_signed <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      if (!w_stall) begin
        r_s1_valid <= w_accept;
        if (w_accept) begin
          r_s1_last   <= last;
          r_s1_signed <= signed_mode;
        end
      end
      // A new result loading on a consume edge keeps out_valid asserted.
      if (w_adv && r_s1_last) begin
        r_out_valid <= 1'b1;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Per-lane datapath
  // --------------------------------------------------------------------------
  generate
    for (genvar i = 0; i < LANES; i++) begin : g_lane
      localparam logic [OUT_W-1:0] c_smax = {1'b0, {(OUT_W-1){1'b1}}};
      localparam logic [OUT_W-1:0] c_smin = {1'b1, {(OUT_W-1){1'b0}}};

      logic [IN_W-1:0]  r_wreg [WREG_DEPTH];
      logic [ACC_W-1:0] r_s1_prod;
      logic [ACC_W-1:0] r_acc;
      logic [OUT_W-1:0] r_out_data;
      logic             r_out_sat;

      logic [IN_W-1:0]          w_act;
      logic [IN_W-1:0]          w_wgt;
      logic [IN_W-1:0]          w_rd;
      logic [IN_W-1:0]          w_op_w;
      logic signed [2*IN_W-1:0] w_a_s;
      logic signed [2*IN_W-1:0] w_b_s;
      logic signed [2*IN_W-1:0] w_prod_s;
      logic [2*IN_W-1:0]        w_prod_u;
      logic [ACC_W-1:0]         w_prod_ext;
      logic [ACC_W-1:0]         w_sum;
      logic [ACC_W-1:0]         w_hi_u;
      logic signed [ACC_W-1:0]  w_hi_s;
      logic                     w_ovf_s;
      logic                     w_ovf_u;
      logic                     w_sat;
      logic [OUT_W-1:0]         w_nar;

      assign w_act  = act[i*IN_W +: IN_W];
      assign w_wgt  = wgt[i*IN_W +: IN_W];
      assign w_rd   = w_rd_ok ? r_wreg[rd_addr] : '0;
      assign w_op_w = use_reg ? w_rd : w_wgt;

      // Full-precision product; the 2*IN_W result cannot overflow.
      assign w_a_s    = (2*IN_W)'($signed(w_act));
      assign w_b_s    = (2*IN_W)'($signed(w_op_w));
      assign w_prod_s = w_a_s * w_b_s;
      assign w_prod_u = (2*IN_W)'(w_act) * (2*IN_W)'(w_op_w);
      assign w_prod_ext = signed_mode ? ACC_W'(w_prod_s) : ACC_W'(w_prod_u);

      assign w_sum = r_acc + r_s1_prod;

      // Value fits iff the bits above the output range are pure extension.
      assign w_hi_u  = w_sum >> OUT_W;
      assign w_hi_s  = $signed(w_sum) >>> (OUT_W-1);
      assign w_ovf_u = |w_hi_u;
      assign w_ovf_s = ~((~|w_hi_s) | (&w_hi_s));
      assign w_sat   = r_s1_signed ? w_ovf_s : w_ovf_u;
      assign w_nar   = !w_sat      ? w_sum[OUT_W-1:0] :
                       r_s1_signed ? (w_sum[ACC_W-1] ? c_smin : c_smax) :
                                     {OUT_W{1'b1}};

      // Reads above see pre-edge contents, giving read-before-write.
      always_ff @(posedge clk) begin
        if (!rst) begin
          for (int k = 0; k < WREG_DEPTH; k++) begin
            r_wreg[k] <= '0;
          end
        end else if (w_wr_ok) begin
          r_wreg[wr_addr] <= w_wgt;
        end
      end

      always_ff @(posedge clk) begin
        if (!rst) begin
          r_s1_prod  <= '0;
          r_acc      <= '0;
          r_out_data <= '0;
          r_out_sat  <= 1'b0;
        end else begin
          if (w_accept) begin
            r_s1_prod <= w_prod_ext;
          end
          if (w_adv) begin
            if (r_s1_last) begin
              r_acc      <= '0;
              r_out_data <= w_nar;
              r_out_sat  <= w_sat;
            end else begin
              r_acc <= w_sum;
            end
          end
        end
      end

      assign out_data[i*OUT_W +: OUT_W] = r_out_data;
      assign out_sat[i]                 = r_out_sat;
    end
  endgenerate

endmodule
`default_nettype wire
